// File: rtl/uart_shell_pkg.sv
// Shared definitions for the UART command-line shell: FSM states,
// character constants and a constant-foldable clog2.
package uart_shell_pkg;

    typedef enum logic [3:0] {
        ST_PROMPT,
        ST_RECV,
        ST_ERASE,
        ST_TERM,
        ST_CMD,
        ST_WAIT_MSG,
        ST_MSG_RD,
        ST_MSG_TX,
        ST_TAIL
    } shell_state_t;

    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_DEL = 8'h7F;
    localparam logic [7:0] CH_BEL = 8'h07;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_TIL = 8'h7E;

    // Smallest r with 2**r >= v (0 for v <= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Small byte FIFO between uart_rx and the shell FSM. A push while full is
// ignored, so the oldest bytes survive; the caller sees full to flag loss.
module uart_byte_fifo
    import uart_shell_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int AW = clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wp;
    logic [AW:0] rp;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rdata = mem[rp[AW-1:0]];

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end

    // Storage, no reset needed: pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle
// rx_valid pulse per byte with a good stop bit.
module uart_rx
    import uart_shell_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data
);
    localparam int CW = clog2(CLKS_PER_BIT) + 1;

    logic [1:0]    sync;
    logic          busy;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    sh;

    // Start detect, then sample every bit period; bit 0 is the start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync     <= 2'b11;
            busy     <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            sh       <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            sync     <= {sync[0], rx};
            rx_valid <= 1'b0;
            if (!busy) begin
                if (!sync[1]) begin
                    busy    <= 1'b1;
                    cnt     <= CW'(CLKS_PER_BIT / 2 - 1);
                    bit_idx <= '0;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                cnt     <= CW'(CLKS_PER_BIT - 1);
                bit_idx <= bit_idx + 4'd1;
                if (bit_idx == 4'd0) begin
                    if (sync[1]) busy <= 1'b0;   // glitch, not a start bit
                end else if (bit_idx == 4'd9) begin
                    busy     <= 1'b0;
                    rx_valid <= sync[1];
                    rx_data  <= sh;
                end else begin
                    sh <= {sync[1], sh[7:1]};
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. tx_busy rises the cycle after tx_start and falls
// once the stop bit has been on the line for a full bit period.
module uart_tx
    import uart_shell_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx
);
    localparam int CW = clog2(CLKS_PER_BIT) + 1;

    logic [9:0]    shreg;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;

    // Line is the LSB of the frame register; ones shift in behind the frame.
    assign tx = shreg[0];

    // Frame shifter: load on start, advance one bit per bit period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '1;
            cnt     <= '0;
            bit_idx <= '0;
            tx_busy <= 1'b0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                shreg   <= {1'b1, tx_data, 1'b0};
                cnt     <= '0;
                bit_idx <= '0;
                tx_busy <= 1'b1;
            end
        end else if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            shreg   <= {1'b1, shreg[9:1]};
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == 4'd9) tx_busy <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_line_shell.sv
// UART command-line front end: prompt, edited line capture with echo into
// the RX buffer region, command pulse, then reply from the TX region.
module uart_line_shell
    import uart_shell_pkg::*;
#(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 115200,
    parameter int LEN        = 128,
    parameter int ADDR_W     = 8,
    parameter int RXSTR_BASE = 0,
    parameter int TXSTR_BASE = 128,
    parameter int PROMPT_LEN = 2,
    parameter logic [8*PROMPT_LEN-1:0] PROMPT = "$ ",
    parameter bit CRLF_OUT   = 1'b1,
    parameter bit MSG_START  = 1'b0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX,
    output logic              TX,
    output logic              cmd_valid,
    output logic [ADDR_W:0]   cmd_len,
    output logic              cmd_ovf,
    output logic              rx_lost,
    output logic              msg_ready,
    input  logic              msg_valid,
    input  logic [ADDR_W:0]   msg_len,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        din,
    input  logic [7:0]        dout,
    output logic              we
);
    localparam int CPB = CLK_FREQ / BAUD;
    localparam logic [ADDR_W:0]   LEN_C  = (ADDR_W+1)'(LEN);
    localparam logic [ADDR_W:0]   ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] RX_BASE = ADDR_W'(RXSTR_BASE);
    localparam logic [ADDR_W-1:0] TX_BASE = ADDR_W'(TXSTR_BASE);

    shell_state_t    state, state_nx;
    logic [3:0]      k, k_nx;              // index within multi-byte sends
    logic [ADDR_W:0] n, n_nx;              // stored line length
    logic [ADDR_W:0] len_q, len_nx;        // clamped reply length
    logic [ADDR_W:0] idx, idx_nx;          // reply byte index
    logic [ADDR_W:0] cmd_len_nx;
    logic            cmd_ovf_nx;
    logic            ovf, ovf_nx;
    logic            lf_skip, lf_skip_nx;
    logic            rd_ph, rd_ph_nx;      // 0: address issued, 1: dout valid
    logic [7:0]      rd_byte, rd_byte_nx;

    logic            tx_start, tx_busy, tx_pend, tx_idle;
    logic [7:0]      tx_byte, prompt_byte;
    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            f_pop, f_full, f_empty;
    logic [7:0]      f_rdata;

    uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
        .clk(clk), .rst(rst), .rx(RX), .rx_valid(rx_valid), .rx_data(rx_data)
    );

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(rx_valid), .wdata(rx_data), .pop(f_pop),
        .rdata(f_rdata), .full(f_full), .empty(f_empty)
    );

    uart_tx #(.CLKS_PER_BIT(CPB)) u_tx (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_byte),
        .tx_busy(tx_busy), .tx(TX)
    );

    // tx_busy lags tx_start by one cycle; tx_pend covers that gap.
    assign tx_idle = !tx_busy && !tx_pend;

    // Prompt byte k, most significant byte first.
    always_comb begin
        prompt_byte = 8'h00;
        for (int j = 0; j < PROMPT_LEN; j++)
            if (k == 4'(j)) prompt_byte = PROMPT[8*(PROMPT_LEN-1-j) +: 8];
    end

    // Next-state, buffer port and single tx_start mux.
    always_comb begin
        state_nx   = state;
        k_nx       = k;
        n_nx       = n;
        len_nx     = len_q;
        idx_nx     = idx;
        ovf_nx     = ovf;
        lf_skip_nx = lf_skip;
        rd_ph_nx   = rd_ph;
        rd_byte_nx = rd_byte;
        cmd_len_nx = cmd_len;
        cmd_ovf_nx = cmd_ovf;
        tx_start   = 1'b0;
        tx_byte    = 8'h00;
        f_pop      = 1'b0;
        we         = 1'b0;
        addr       = '0;
        din        = 8'h00;
        msg_ready  = 1'b0;
        cmd_valid  = 1'b0;
        case (state)
            ST_PROMPT: if (tx_idle) begin
                if (k == 4'(PROMPT_LEN)) begin
                    state_nx = ST_RECV;
                    k_nx     = '0;
                    n_nx     = '0;
                end else begin
                    tx_start = 1'b1;
                    tx_byte  = prompt_byte;
                    k_nx     = k + 4'd1;
                end
            end
            ST_RECV: if (tx_idle && !f_empty) begin
                f_pop      = 1'b1;
                lf_skip_nx = 1'b0;
                if (f_rdata >= CH_SP && f_rdata <= CH_TIL) begin
                    tx_start = 1'b1;
                    if (n < LEN_C) begin
                        we      = 1'b1;
                        addr    = RX_BASE + n[ADDR_W-1:0];
                        din     = f_rdata;
                        tx_byte = f_rdata;
                        n_nx    = n + ONE;
                    end else begin
                        ovf_nx  = 1'b1;
                        tx_byte = CH_BEL;
                    end
                end else if (f_rdata == CH_BS || f_rdata == CH_DEL) begin
                    if (n != '0) begin
                        n_nx     = n - ONE;
                        state_nx = ST_ERASE;
                        k_nx     = '0;
                    end
                end else if (f_rdata == CH_CR) begin
                    state_nx   = ST_TERM;
                    k_nx       = '0;
                    lf_skip_nx = 1'b1;
                end else if (f_rdata == CH_LF && !lf_skip) begin
                    state_nx = ST_TERM;
                    k_nx     = '0;
                end
            end
            ST_ERASE: if (tx_idle) begin
                if (k == 4'd3) begin
                    state_nx = ST_RECV;
                end else begin
                    tx_start = 1'b1;
                    tx_byte  = (k == 4'd1) ? CH_SP : CH_BS;
                    k_nx     = k + 4'd1;
                end
            end
            ST_TERM: if (tx_idle) begin
                if (k == 4'd2) begin
                    k_nx = '0;
                    if (n == '0 && !ovf) begin
                        state_nx = ST_PROMPT;
                    end else begin
                        state_nx   = ST_CMD;
                        cmd_len_nx = n;
                        cmd_ovf_nx = ovf;
                    end
                end else begin
                    tx_start = 1'b1;
                    tx_byte  = (k == 4'd1) ? CH_LF : CH_CR;
                    k_nx     = k + 4'd1;
                end
            end
            ST_CMD: begin
                cmd_valid = 1'b1;
                ovf_nx    = 1'b0;
                state_nx  = ST_WAIT_MSG;
            end
            ST_WAIT_MSG: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    len_nx   = (msg_len > LEN_C) ? LEN_C : msg_len;
                    idx_nx   = '0;
                    k_nx     = '0;
                    rd_ph_nx = 1'b0;
                    state_nx = (msg_len == '0) ? ST_TAIL : ST_MSG_RD;
                end
            end
            ST_MSG_RD: begin
                addr = TX_BASE + idx[ADDR_W-1:0];
                if (!rd_ph) begin
                    rd_ph_nx = 1'b1;
                end else begin
                    rd_byte_nx = dout;
                    rd_ph_nx   = 1'b0;
                    state_nx   = ST_MSG_TX;
                end
            end
            ST_MSG_TX: if (tx_idle) begin
                tx_start = 1'b1;
                tx_byte  = rd_byte;
                idx_nx   = idx + ONE;
                k_nx     = '0;
                state_nx = (idx + ONE == len_q) ? ST_TAIL : ST_MSG_RD;
            end
            ST_TAIL: begin
                if (!CRLF_OUT) begin
                    state_nx = ST_PROMPT;
                    k_nx     = '0;
                end else if (tx_idle) begin
                    if (k == 4'd2) begin
                        state_nx = ST_PROMPT;
                        k_nx     = '0;
                    end else begin
                        tx_start = 1'b1;
                        tx_byte  = (k == 4'd1) ? CH_LF : CH_CR;
                        k_nx     = k + 4'd1;
                    end
                end
            end
            default: state_nx = ST_PROMPT;
        endcase
    end

    // FSM state and line/reply registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= MSG_START ? ST_WAIT_MSG : ST_PROMPT;
            k       <= '0;
            n       <= '0;
            len_q   <= '0;
            idx     <= '0;
            ovf     <= 1'b0;
            lf_skip <= 1'b0;
            rd_ph   <= 1'b0;
            rd_byte <= 8'h00;
            cmd_len <= '0;
            cmd_ovf <= 1'b0;
        end else begin
            state   <= state_nx;
            k       <= k_nx;
            n       <= n_nx;
            len_q   <= len_nx;
            idx     <= idx_nx;
            ovf     <= ovf_nx;
            lf_skip <= lf_skip_nx;
            rd_ph   <= rd_ph_nx;
            rd_byte <= rd_byte_nx;
            cmd_len <= cmd_len_nx;
            cmd_ovf <= cmd_ovf_nx;
        end
    end

    // Start handshake tracking and sticky RX loss flag (a new loss wins over clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_pend <= 1'b0;
            rx_lost <= 1'b0;
        end else begin
            tx_pend <= tx_start;
            if (rx_valid && f_full) rx_lost <= 1'b1;
            else if (cmd_valid)     rx_lost <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_line_shell.sv
// Scoreboard bench for uart_line_shell: expected TX bytes, buffer writes and
// command pulses are queued by the stimulus and consumed by monitors.
module tb_uart_line_shell;
    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX;
    logic       TX;
    logic       cmd_valid, cmd_ovf, rx_lost, msg_ready, msg_valid, we;
    logic [8:0] cmd_len, msg_len;
    logic [7:0] addr, din, dout;

    logic       TX2, cmd_valid2, cmd_ovf2, rx_lost2, msg_ready2, we2;
    logic [8:0] cmd_len2;
    logic [7:0] addr2, din2;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_tx[$];
    logic [15:0] exp_wr[$];
    logic [9:0]  exp_cmd[$];

    logic [7:0] ram [0:255];
    logic       pl_we = 1'b0;
    logic [7:0] pl_addr = 8'h00, pl_data = 8'h00;

    always #5 clk = ~clk;

    uart_line_shell #(.CLK_FREQ(800), .BAUD(100), .LEN(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd_valid(cmd_valid),
        .cmd_len(cmd_len), .cmd_ovf(cmd_ovf), .rx_lost(rx_lost),
        .msg_ready(msg_ready), .msg_valid(msg_valid), .msg_len(msg_len),
        .addr(addr), .din(din), .dout(dout), .we(we)
    );

    uart_line_shell #(.CLK_FREQ(800), .BAUD(100), .LEN(4), .MSG_START(1'b1)) dut2 (
        .clk(clk), .rst(rst), .RX(1'b1), .TX(TX2), .cmd_valid(cmd_valid2),
        .cmd_len(cmd_len2), .cmd_ovf(cmd_ovf2), .rx_lost(rx_lost2),
        .msg_ready(msg_ready2), .msg_valid(1'b0), .msg_len(9'd0),
        .addr(addr2), .din(din2), .dout(8'h00), .we(we2)
    );

    // Shared buffer model with one-cycle read latency and a bench preload port.
    always @(posedge clk) begin
        if (we) ram[addr] <= din;
        else if (pl_we) ram[pl_addr] <= pl_data;
        dout <= ram[addr];
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // TX wire decoder.
    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && TX === 1'b0) begin
                repeat (CPB/2) @(negedge clk);
                b = 8'h00;
                for (int j = 0; j < 8; j++) begin
                    repeat (CPB) @(negedge clk);
                    b[j] = TX;
                end
                repeat (CPB) @(negedge clk);
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL tx_byte: got unexpected %h, expected nothing", b);
                end else begin
                    logic [7:0] e;
                    e = exp_tx.pop_front();
                    if (b !== e) begin
                        errors++;
                        $display("FAIL tx_byte: got %h, expected %h", b, e);
                    end
                end
            end
        end
    end

    // Buffer write and command pulse monitors.
    always @(negedge clk) begin
        if (!rst && we) begin
            if (exp_wr.size() == 0) chk("wr_unexpected", {addr, din}, 16'hxxxx);
            else chk("buf_write", {addr, din}, exp_wr.pop_front());
        end
        if (!rst && cmd_valid) begin
            if (exp_cmd.size() == 0) chk("cmd_unexpected", {6'd0, cmd_len, cmd_ovf}, 16'hxxxx);
            else chk("cmd", {6'd0, cmd_len, cmd_ovf}, {6'd0, exp_cmd.pop_front()});
        end
    end

    task automatic exp_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            RX = b[j];
            repeat (CPB) @(negedge clk);
        end
        RX = 1'b1;
        repeat (3*CPB) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic preload(input logic [7:0] a, input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            pl_we = 1'b1; pl_addr = a + 8'(i); pl_data = s[i];
        end
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int t;
        t = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0 || exp_cmd.size() != 0) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 4000) begin
            errors++;
            $display("FAIL %s: timeout with tx=%0d wr=%0d cmd=%0d pending, expected 0",
                     nm, exp_tx.size(), exp_wr.size(), exp_cmd.size());
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_ready(input string nm);
        int t;
        t = 0;
        while (msg_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(nm, {15'd0, msg_ready}, 16'd1);
    endtask

    task automatic send_msg(input logic [8:0] l);
        @(negedge clk);
        msg_valid = 1'b1; msg_len = l;
        @(negedge clk);
        msg_valid = 1'b0; msg_len = 9'd0;
    endtask

    initial begin
        logic tx2_low;
        rst = 1'b1; RX = 1'b1; msg_valid = 1'b0; msg_len = 9'd0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", {15'd0, cmd_valid}, 16'd0);
        chk("rst_cmd_len",   {7'd0, cmd_len}, 16'd0);
        chk("rst_cmd_ovf",   {15'd0, cmd_ovf}, 16'd0);
        chk("rst_rx_lost",   {15'd0, rx_lost}, 16'd0);
        chk("rst_msg_ready", {15'd0, msg_ready}, 16'd0);
        chk("rst_addr_din",  {addr, din}, 16'd0);
        chk("rst_we_tx",     {14'd0, we, TX}, 16'd1);

        exp_str("$ ");
        rst = 1'b0;

        // Plain line.
        exp_str("ab\r\n");
        exp_wr.push_back({8'd0, 8'h61}); exp_wr.push_back({8'd1, 8'h62});
        exp_cmd.push_back({9'd2, 1'b0});
        send_str("ab\r");
        wait_drain("line_ab");
        wait_ready("ready_after_ab");

        // Reply "OK!".
        preload(8'd128, "OK!");
        exp_str("OK!\r\n$ ");
        send_msg(9'd3);
        wait_drain("reply_ok");

        // Backspace edit.
        exp_str("abc"); exp_tx.push_back(8'h08); exp_tx.push_back(8'h20);
        exp_tx.push_back(8'h08); exp_str("d\r\n");
        exp_wr.push_back({8'd0, 8'h61}); exp_wr.push_back({8'd1, 8'h62});
        exp_wr.push_back({8'd2, 8'h63}); exp_wr.push_back({8'd2, 8'h64});
        exp_cmd.push_back({9'd3, 1'b0});
        send_str("abc"); send_byte(8'h08); send_str("d\r");
        wait_drain("line_bs");
        chk("buf_abd", {ram[0], ram[1]}, 16'h6162);
        chk("buf_abd2", {8'd0, ram[2]}, 16'h0064);
        wait_ready("ready_after_bs");

        // Empty reply.
        exp_str("\r\n$ ");
        send_msg(9'd0);
        wait_drain("reply_empty");

        // Empty line with stray backspace and CRLF: no command.
        exp_str("\r\n$ ");
        send_byte(8'h08); send_str("\r\n");
        wait_drain("empty_line");
        repeat (200) @(negedge clk);
        chk("no_cmd_ready", {15'd0, msg_ready}, 16'd0);

        // Overflow at LEN=4.
        exp_str("abcd"); exp_tx.push_back(8'h07); exp_tx.push_back(8'h07);
        exp_str("\r\n");
        for (int i = 0; i < 4; i++) exp_wr.push_back({8'(i), 8'(8'h61 + i)});
        exp_cmd.push_back({9'd4, 1'b1});
        send_str("abcdef\r");
        wait_drain("line_ovf");
        wait_ready("ready_after_ovf");

        // FIFO overrun while waiting for a reply; oldest four bytes kept.
        chk("rx_lost_clear", {15'd0, rx_lost}, 16'd0);
        send_str("pqrstu");
        chk("rx_lost_set", {15'd0, rx_lost}, 16'd1);
        preload(8'd128, "WXYZ#");
        exp_str("WXYZ\r\n$ pqrs");
        for (int i = 0; i < 4; i++) exp_wr.push_back({8'(i), 8'(8'h70 + i)});
        send_msg(9'd200);
        wait_drain("reply_clamp");
        chk("rx_lost_sticky", {15'd0, rx_lost}, 16'd1);
        exp_str("\r\n");
        exp_cmd.push_back({9'd4, 1'b0});
        send_byte(8'h0D);
        wait_drain("line_pqrs");
        chk("rx_lost_cleared", {15'd0, rx_lost}, 16'd0);

        // MSG_START instance: ready after reset, never sent a prompt.
        tx2_low = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (TX2 !== 1'b1) tx2_low = 1'b1;
        end
        chk("msgstart_ready", {15'd0, msg_ready2}, 16'd1);
        chk("msgstart_no_prompt", {15'd0, tx2_low}, 16'd0);

        chk("queues_empty", 16'(exp_tx.size() + exp_wr.size() + exp_cmd.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global safety net.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

endmodule
